// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Two-requester arbiter in front of a small 4-bit ALU. One operation is in
//   flight at a time and runs IDLE -> EXEC -> DONE. The winner's operands are
//   captured on the grant edge, so the requester may change them or drop its
//   request afterwards without affecting the operation.
//
// Parameters
//   RR_EN      1: round-robin on ties, 0: requester 0 has fixed priority
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req0/req1  operation request per requester (held until grant)
//   a0,b0,op0  requester 0 operands / op (00 add, 01 sub, 10 and, 11 or)
//   a1,b1,op1  requester 1 operands / op
//   gnt0/gnt1  one-cycle grant pulse (EXEC cycle)
//   done0/1    one-cycle completion pulse (DONE cycle)
//   result     registered ALU result, held until the next completion
//   carry_out  registered carry (add only, else 0)
//   busy       high while not IDLE
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [1:0] op0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic [1:0] op1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] result,
  output logic       carry_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t     state_q;
  logic       owner_q;     // 1: requester 1 owns the in-flight operation
  logic       last_q;      // last granted requester (1: requester 1)
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [1:0] op_q;
  logic [3:0] result_q;
  logic       carry_q;
  logic       gnt0_q;
  logic       gnt1_q;
  logic       done0_q;
  logic       done1_q;
  logic       busy_q;

  logic       winner_d;    // 1: requester 1 wins this edge
  logic [3:0] a_d;
  logic [3:0] b_d;
  logic [1:0] op_d;
  logic [4:0] alu_d;

  // 4-bit ALU; bit 4 of the return value is the carry (add only).
  function automatic logic [4:0] alu_calc(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic [1:0] op);
    logic [4:0] r;
    case (op)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {1'b0, a - b};
      2'b10:   r = {1'b0, a & b};
      2'b11:   r = {1'b0, a | b};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Winner selection and operand mux for the grant edge.
  always_comb begin
    winner_d = 1'b0;
    if (req0 && req1) begin
      // Tie: round-robin favours whoever did not win last time.
      if (RR_EN) begin
        winner_d = ~last_q;
      end else begin
        winner_d = 1'b0;
      end
    end else if (req1) begin
      winner_d = 1'b1;
    end else begin
      winner_d = 1'b0;
    end

    if (winner_d) begin
      a_d  = a1;
      b_d  = b1;
      op_d = op1;
    end else begin
      a_d  = a0;
      b_d  = b0;
      op_d = op0;
    end

    alu_d = alu_calc(a_q, b_q, op_q);
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      a_q      <= 4'h0;
      b_q      <= 4'h0;
      op_q     <= 2'b00;
      result_q <= 4'h0;
      carry_q  <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          if (req0 || req1) begin
            state_q <= S_EXEC;
            owner_q <= winner_d;
            last_q  <= winner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            gnt0_q  <= ~winner_d;
            gnt1_q  <= winner_d;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        S_EXEC: begin
          state_q  <= S_DONE;
          result_q <= alu_d[3:0];
          carry_q  <= alu_d[4];
          gnt0_q   <= 1'b0;
          gnt1_q   <= 1'b0;
          done0_q  <= ~owner_q;
          done1_q  <= owner_q;
          busy_q   <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Table-driven bench for alu_arbiter with a result scoreboard. A round-robin
//   instance is the main DUT; a fixed-priority instance shares its inputs and
//   is checked during the continuous-contention sequence.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic [1:0] op0, op1;

  logic       gnt0, gnt1, done0, done1, carry_out, busy;
  logic [3:0] result;
  logic       f_gnt0, f_gnt1, f_done0, f_done1, f_carry, f_busy;
  logic [3:0] f_result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [1:0] op0;
    logic [3:0] a1;
    logic [3:0] b1;
    logic [1:0] op1;
    logic       win1;
    logic [3:0] res;
    logic       cy;
  } vec_t;

  typedef struct {
    logic       win1;
    logic [3:0] res;
    logic       cy;
  } exp_t;

  exp_t sb[$];
  vec_t vt[11];

  alu_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .carry_out(carry_out), .busy(busy)
  );

  alu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .gnt0(f_gnt0), .gnt1(f_gnt1), .done0(f_done0), .done1(f_done1),
    .result(f_result), .carry_out(f_carry), .busy(f_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_gnt0"}, {7'd0, gnt0}, 8'd0);
    chk({tag, "_gnt1"}, {7'd0, gnt1}, 8'd0);
    chk({tag, "_done"}, {6'd0, done1, done0}, 8'd0);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_result"}, {4'd0, result}, 8'd0);
    chk({tag, "_carry"}, {7'd0, carry_out}, 8'd0);
  endtask

  // One operation: drive, check grant, scramble inputs, wait for done, compare.
  task automatic run_op(input vec_t v, input string tag);
    exp_t e;
    bit   got;
    @(negedge clk);
    req0 = v.r0; a0 = v.a0; b0 = v.b0; op0 = v.op0;
    req1 = v.r1; a1 = v.a1; b1 = v.b1; op1 = v.op1;
    sb.push_back('{win1: v.win1, res: v.res, cy: v.cy});
    @(posedge clk); #1;
    chk({tag, "_gnt0"}, {7'd0, gnt0}, {7'd0, !v.win1});
    chk({tag, "_gnt1"}, {7'd0, gnt1}, {7'd0, v.win1});
    chk({tag, "_busy_exec"}, {7'd0, busy}, 8'd1);
    // The in-flight operation must ignore everything after the grant edge.
    req0 = 1'b0; req1 = 1'b0;
    a0 = 4'($urandom); b0 = 4'($urandom); op0 = 2'($urandom);
    a1 = 4'($urandom); b1 = 4'($urandom); op1 = 2'($urandom);
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (done0 || done1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout: got no done expected done within 4 cycles", tag);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk({tag, "_done0"}, {7'd0, done0}, {7'd0, !e.win1});
      chk({tag, "_done1"}, {7'd0, done1}, {7'd0, e.win1});
      chk({tag, "_result"}, {4'd0, result}, {4'd0, e.res});
      chk({tag, "_carry"}, {7'd0, carry_out}, {7'd0, e.cy});
      chk({tag, "_busy_done"}, {7'd0, busy}, 8'd1);
    end
    @(posedge clk); #1;
    chk({tag, "_busy_idle"}, {7'd0, busy}, 8'd0);
    chk({tag, "_done_clear"}, {6'd0, done1, done0}, 8'd0);
    chk({tag, "_result_hold"}, {4'd0, result}, {4'd0, v.res});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic eg0, eg1;
    vec_t v;

    // Round-robin starts with last winner = requester 1.
    //           r0    r1    a0    b0    op0    a1    b1    op1    w1    res   cy
    vt[0]  = '{1'b1, 1'b0, 4'h9, 4'h8, 2'b00, 4'h0, 4'h0, 2'b00, 1'b0, 4'h1, 1'b1};
    vt[1]  = '{1'b0, 1'b1, 4'h0, 4'h0, 2'b00, 4'h3, 4'h5, 2'b01, 1'b1, 4'hE, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 4'h0, 4'h0, 2'b00, 4'hC, 4'hA, 2'b10, 1'b1, 4'h8, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 4'h0, 4'h0, 2'b00, 4'hC, 4'hA, 2'b11, 1'b1, 4'hE, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 4'hF, 4'h1, 2'b00, 4'h2, 4'h2, 2'b00, 1'b0, 4'h0, 1'b1};
    vt[5]  = '{1'b1, 1'b1, 4'h1, 4'h1, 2'b00, 4'h2, 4'h7, 2'b01, 1'b1, 4'hB, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 4'h6, 4'h3, 2'b10, 4'h5, 4'hA, 2'b11, 1'b0, 4'h2, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 4'h0, 4'h1, 2'b01, 4'h0, 4'h0, 2'b00, 1'b0, 4'hF, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 4'h0, 4'h0, 2'b00, 4'h5, 4'hA, 2'b11, 1'b1, 4'hF, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 4'h7, 4'h1, 2'b00, 4'h0, 4'h0, 2'b00, 1'b0, 4'h8, 1'b0};
    vt[10] = '{1'b1, 1'b0, 4'hF, 4'hF, 2'b00, 4'h0, 4'h0, 2'b00, 1'b0, 4'hE, 1'b1};

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 4'h0; b0 = 4'h0; op0 = 2'b00;
    a1 = 4'h0; b1 = 4'h0; op1 = 2'b00;
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(vt[i], $sformatf("vec%0d", i));
    end

    // Continuous contention from reset: RR alternates, fixed priority stays on 0.
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b1; a0 = 4'h1; b0 = 4'h1; op0 = 2'b00;
    req1 = 1'b1; a1 = 4'h4; b1 = 4'h2; op1 = 2'b01;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      eg0 = (i % 3 == 0) && ((i / 3) % 2 == 0);
      eg1 = (i % 3 == 0) && ((i / 3) % 2 == 1);
      chk($sformatf("rr_gnt0_c%0d", i), {7'd0, gnt0}, {7'd0, eg0});
      chk($sformatf("rr_gnt1_c%0d", i), {7'd0, gnt1}, {7'd0, eg1});
      chk($sformatf("fp_gnt0_c%0d", i), {7'd0, f_gnt0}, {7'd0, (i % 3 == 0)});
      chk($sformatf("fp_gnt1_c%0d", i), {7'd0, f_gnt1}, 8'd0);
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("contention_drain_busy", {7'd0, busy}, 8'd0);

    // Reset during EXEC of a requester-1 operation: aborted, no done.
    do_reset();
    @(negedge clk);
    req1 = 1'b1; a1 = 4'h3; b1 = 4'h3; op1 = 2'b00;
    @(posedge clk); #1;
    chk("abort_gnt1", {7'd0, gnt1}, 8'd1);
    @(negedge clk);
    rst_n = 1'b0;
    req1 = 1'b0;
    #1;
    check_idle_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_no_done_c%0d", i), {6'd0, done1, done0}, 8'd0);
    end
    v = '{1'b0, 1'b1, 4'h0, 4'h0, 2'b00, 4'h6, 4'h5, 2'b00, 1'b1, 4'hB, 1'b0};
    run_op(v, "post_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1; 1 = round-robin arbitration, 0 = fixed priority with requester 0 always winning.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0  input  1  requester 0 operation request; held high until gnt0.
REQ-005 a0, b0  input  4 each  requester 0 operands.
REQ-006 op0  input  2  requester 0 op select: 00 add, 01 sub, 10 AND, 11 OR.
REQ-007 req1, a1, b1, op1  input  1/4/4/2  requester 1 request, operands and op select, same meaning as requester 0.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands captured.
REQ-009 done0, done1  output  1 each  one-cycle completion pulse to the owning requester.
REQ-010 result  output  4  registered ALU result.
REQ-011 carry_out  output  1  registered carry; meaningful for add only.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states are IDLE, EXEC and DONE; there are no other reachable states.
REQ-014 IDLE: if no request is high, the FSM remains in IDLE.
REQ-015 IDLE: if req0 or req1 is high at a rising edge, the FSM selects a winner at that edge and moves to EXEC.
REQ-016 On the IDLE-to-EXEC edge, the winner's a, b and op are latched into internal operand registers.
REQ-017 gnt of the winner is high for exactly the EXEC cycle.
REQ-018 EXEC to DONE, unconditionally at the next edge.
REQ-019 On the EXEC-to-DONE edge, result and carry_out are registered from the latched operands.
REQ-020 DONE: done of the owning requester is high for exactly one cycle; the FSM then returns to IDLE.
REQ-021 Fixed timing: request sampled at edge k; gnt high in cycle k+1; done and the new result are valid in cycle k+2; IDLE again from edge k+3.
REQ-022 Throughput is at most one operation per 3 cycles; requests are not sampled while busy=1.
REQ-023 Add: result = (A+B) mod 16; carry_out = bit 4 of the 5-bit sum.
REQ-024 Sub: result = (A−B) mod 16, two's-complement wrap; carry_out = 0.
REQ-025 AND and OR: bitwise on the 4 operand bits; carry_out = 0.
REQ-026 result and carry_out hold their value from the last DONE until the next EXEC-to-DONE edge.
REQ-027 Round-robin (RR_EN=1): a last-winner register is updated at each grant.
REQ-028 Round-robin, both requests high: the requester that is not the last winner wins.
REQ-029 Round-robin, single request: that requester wins regardless of the last winner.
REQ-030 Fixed priority (RR_EN=0): requester 0 wins whenever req0=1.
REQ-031 Operands or op changing after the grant edge, or req dropping during EXEC or DONE, do not affect the in-flight operation; it completes and done still pulses.
REQ-032 A requester still holding req high in DONE is eligible again at the next IDLE edge.
REQ-033 gnt0 and gnt1 are never high together; done0 and done1 are never high together.

Reset
REQ-034 While rst_n=0: state = IDLE, gnt0 = gnt1 = done0 = done1 = 0, busy = 0, result = 4'h0, carry_out = 0, operand registers = 0.
REQ-035 While rst_n=0, the last-winner register = requester 1, so requester 0 wins the first tie.
REQ-036 Reset asserted mid-operation (EXEC or DONE) aborts the operation immediately; no done pulse is produced for it.
REQ-037 The first request is sampled at the first rising edge with rst_n=1.

Verification
REQ-038 req0=1, a0=4'h9, b0=4'h8, op0=00 from IDLE -> gnt0 next cycle; done0 one cycle later; result=4'h1, carry_out=1, busy high for 2 cycles.
REQ-039 req1=1, a1=4'h3, b1=4'h5, op1=01 -> done1 with result=4'hE, carry_out=0; ops 10 and 11 on 4'hC, 4'hA -> results 4'h8 and 4'hE.
REQ-040 RR_EN=1, req0 and req1 held high continuously after reset -> grants alternate gnt0, gnt1, gnt0, ..., one grant every 3 cycles; RR_EN=0 with the same stimulus -> gnt0 only.
REQ-041 req0 grant with a0=4'h7, b0=4'h1, op0=00; during EXEC change a0 to 4'hF and drop req0 -> done0 still pulses with result=4'h8.
REQ-042 rst_n pulsed low during EXEC of a req1 operation -> no done1; all outputs zero; the next request is granted normally after release.
